// File: rtl/score_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : score_pkg                                                     |
// | Purpose    : Shared definitions for the score keeper: FSM state encoding   |
// |              and width-generic helpers for one-hot checking and            |
// |              saturating / wrapping add and subtract.                       |
// | Contents   : state_t (ST_IDLE, ST_WAIT_REL), MAX_W, onehot_chk(),          |
// |              sat_add(), sat_sub()                                          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package score_pkg;

  // Widest operand the helpers handle. Callers zero-extend into this width
  // and truncate the result back to their own width.
  localparam int MAX_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_REL = 1'b1
  } state_t;

  // True when exactly one of the low n bits of v is set.
  function automatic logic onehot_chk(input logic [MAX_W-1:0] v, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n && v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // s + pts evaluated one bit wider than w, then clamped to 2**w-1 (sat=1)
  // or reduced modulo 2**w (sat=0).
  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] s,
                                               input logic [MAX_W-1:0] pts,
                                               input int               w,
                                               input logic             sat);
    logic [MAX_W:0] top;
    logic [MAX_W:0] sum;
    top = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    sum = {1'b0, s} + {1'b0, pts};
    if (sat && (sum > top)) sum = top;
    return MAX_W'(sum & top);
  endfunction

  // s - pts floored at 0 (sat=1) or reduced modulo 2**w (sat=0).
  function automatic logic [MAX_W-1:0] sat_sub(input logic [MAX_W-1:0] s,
                                               input logic [MAX_W-1:0] pts,
                                               input int               w,
                                               input logic             sat);
    logic [MAX_W:0] top;
    logic [MAX_W:0] diff;
    top  = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    diff = {1'b0, s} - {1'b0, pts};
    if (sat && (pts > s)) diff = '0;
    return MAX_W'(diff & top);
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface  : score_keeper_if                                               |
// | Purpose    : Host/buzz-path side bundle of the score keeper.               |
// | Signals    : true, false  host verdict levels                              |
// |              en_s         one-hot answer-valid hold (bit i = team i)       |
// |              clr          synchronous score clear                          |
// |              zd_r, err    one-cycle applied / rejected pulses              |
// |              EDA_fs       packed scores, team i at [i*SCORE_W +: SCORE_W]  |
// |              lead_id,     registered leader index / any-score-non-zero     |
// |              lead_v                                                        |
// | Modports   : master (host side), slave (score keeper)                      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface score_keeper_if #(
  parameter int N_TEAMS = 4,
  parameter int SCORE_W = 4
);
  localparam int ID_W = $clog2(N_TEAMS);

  logic                       true;
  logic                       false;
  logic [N_TEAMS-1:0]         en_s;
  logic                       clr;
  logic                       zd_r;
  logic                       err;
  logic [N_TEAMS*SCORE_W-1:0] EDA_fs;
  logic [ID_W-1:0]            lead_id;
  logic                       lead_v;

  modport master (
    output true, false, en_s, clr,
    input  zd_r, err, EDA_fs, lead_id, lead_v
  );

  modport slave (
    input  true, false, en_s, clr,
    output zd_r, err, EDA_fs, lead_id, lead_v
  );

endinterface
`default_nettype wire

// File: rtl/score_leader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : score_leader                                                  |
// | Purpose    : Finds the highest-scoring team (lowest index on a tie) and    |
// |              whether any score is non-zero, then registers both.           |
// | Ports      : clk_count  in   clock, rising edge                            |
// |              rst_n      in   synchronous active-low reset                  |
// |              scores     in   packed scores, team i at [i*SCORE_W+:SCORE_W] |
// |              lead_id    out  registered argmax index                       |
// |              lead_v     out  registered OR of (score != 0)                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module score_leader #(
  parameter int N_TEAMS = 4,
  parameter int SCORE_W = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk_count,
  input  logic                       rst_n,
  input  logic [N_TEAMS*SCORE_W-1:0] scores,
  output logic [ID_W-1:0]            lead_id,
  output logic                       lead_v
);

  logic [ID_W-1:0]    best_idx;
  logic [SCORE_W-1:0] best_val;
  logic               any_nz;

  // Ascending scan with a strict compare: a later team only takes the lead
  // when it is strictly ahead, so ties stay with the lower index. With all
  // scores zero this leaves index 0.
  always_comb begin
    best_idx = '0;
    best_val = scores[0 +: SCORE_W];
    any_nz   = 1'b0;
    for (int i = 0; i < N_TEAMS; i++) begin
      if (scores[i*SCORE_W +: SCORE_W] > best_val) begin
        best_val = scores[i*SCORE_W +: SCORE_W];
        best_idx = ID_W'(i);
      end
      if (scores[i*SCORE_W +: SCORE_W] != '0) any_nz = 1'b1;
    end
  end

  always_ff @(posedge clk_count) begin
    if (!rst_n) begin
      lead_id <= '0;
      lead_v  <= 1'b0;
    end else begin
      lead_id <= best_idx;
      lead_v  <= any_nz;
    end
  end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : score_keeper                                                  |
// | Purpose    : N-team score recorder. Applies one host verdict per          |
// |              assertion to the team selected by the one-hot en_s, with      |
// |              optional penalty, saturating or wrapping arithmetic, error    |
// |              flagging, host clear and leader tracking.                     |
// | Ports      : clk_count  in   clock, rising edge                            |
// |              rst_n      in   synchronous active-low reset                  |
// |              bus        slave modport of score_keeper_if                   |
// |                         (true/false/en_s/clr in; zd_r/err/EDA_fs/          |
// |                          lead_id/lead_v out)                               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module score_keeper #(
  parameter int N_TEAMS   = 4,
  parameter int SCORE_W   = 4,
  parameter int PTS_RIGHT = 1,
  parameter int PTS_WRONG = 0,
  parameter int SATURATE  = 1
) (
  input  logic         clk_count,
  input  logic         rst_n,
  score_keeper_if.slave bus
);
  import score_pkg::*;

  localparam int ID_W = $clog2(N_TEAMS);

  // Elaboration-time parameter guards.
  if (N_TEAMS < 2 || N_TEAMS > 16) begin : g_bad_teams
    $error("score_keeper: N_TEAMS must be in 2..16");
  end
  if (SCORE_W < 1 || SCORE_W > 31) begin : g_bad_width
    $error("score_keeper: SCORE_W must be in 1..31");
  end
  if (PTS_RIGHT < 0 || PTS_RIGHT >= (1 << SCORE_W)) begin : g_bad_right
    $error("score_keeper: PTS_RIGHT must be below 2**SCORE_W");
  end
  if (PTS_WRONG < 0 || PTS_WRONG >= (1 << SCORE_W)) begin : g_bad_wrong
    $error("score_keeper: PTS_WRONG must be below 2**SCORE_W");
  end

  state_t                     state;
  logic                       zd_q;
  logic                       err_q;
  logic                       verdict;
  logic                       legal;
  logic                       apply;
  logic [N_TEAMS*SCORE_W-1:0] scores_flat;
  logic [ID_W-1:0]            lead_id;
  logic                       lead_v;

  // true&false gives verdict=0, so it can never look legal.
  assign verdict = bus.true ^ bus.false;
  assign legal   = verdict && onehot_chk(MAX_W'(bus.en_s), N_TEAMS);
  // Score update strobe; clr wins over a verdict arriving in the same cycle.
  assign apply   = (state == ST_IDLE) && !bus.clr && legal;

  always_ff @(posedge clk_count) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      zd_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      zd_q  <= 1'b0;
      err_q <= 1'b0;
      if (bus.clr) begin
        // Parking in WAIT_REL swallows any verdict held across the clear.
        state <= ST_WAIT_REL;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.true || bus.false) begin
              state <= ST_WAIT_REL;
              if (legal) zd_q  <= 1'b1;
              else       err_q <= 1'b1;
            end
          end
          ST_WAIT_REL: begin
            if (!bus.true && !bus.false) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_TEAMS; i++) begin : g_team
    logic [SCORE_W-1:0] score;

    always_ff @(posedge clk_count) begin
      if (!rst_n || bus.clr) begin
        score <= '0;
      end else if (apply && bus.en_s[i]) begin
        if (bus.true)
          score <= SCORE_W'(sat_add(MAX_W'(score), MAX_W'(PTS_RIGHT), SCORE_W,
                                    SATURATE != 0));
        else
          score <= SCORE_W'(sat_sub(MAX_W'(score), MAX_W'(PTS_WRONG), SCORE_W,
                                    SATURATE != 0));
      end
    end

    assign scores_flat[i*SCORE_W +: SCORE_W] = score;
  end

  score_leader #(
    .N_TEAMS (N_TEAMS),
    .SCORE_W (SCORE_W),
    .ID_W    (ID_W)
  ) u_leader (
    .clk_count (clk_count),
    .rst_n     (rst_n),
    .scores    (scores_flat),
    .lead_id   (lead_id),
    .lead_v    (lead_v)
  );

  assign bus.zd_r    = zd_q;
  assign bus.err     = err_q;
  assign bus.EDA_fs  = scores_flat;
  assign bus.lead_id = lead_id;
  assign bus.lead_v  = lead_v;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_score_keeper                                               |
// | Purpose    : Self-checking bench for score_keeper. Three 4-team instances  |
// |              (default, penalty+saturate, penalty+wrap) share stimulus; an  |
// |              8-team 6-bit instance has its own stimulus and reset.         |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_score_keeper;

  logic clk_count = 1'b0;
  always #5 clk_count = ~clk_count;

  logic       rst_n;
  logic       t, f, clr;
  logic [3:0] en;

  logic       rst_d;
  logic       d_t, d_f, d_clr;
  logic [7:0] d_en;

  int checks = 0;
  int errors = 0;

  score_keeper_if #(.N_TEAMS(4), .SCORE_W(4)) if_a ();
  score_keeper_if #(.N_TEAMS(4), .SCORE_W(4)) if_b ();
  score_keeper_if #(.N_TEAMS(4), .SCORE_W(4)) if_c ();
  score_keeper_if #(.N_TEAMS(8), .SCORE_W(6)) if_d ();

  assign if_a.true = t;   assign if_a.false = f;   assign if_a.en_s = en;   assign if_a.clr = clr;
  assign if_b.true = t;   assign if_b.false = f;   assign if_b.en_s = en;   assign if_b.clr = clr;
  assign if_c.true = t;   assign if_c.false = f;   assign if_c.en_s = en;   assign if_c.clr = clr;
  assign if_d.true = d_t; assign if_d.false = d_f; assign if_d.en_s = d_en; assign if_d.clr = d_clr;

  score_keeper #(.N_TEAMS(4), .SCORE_W(4), .PTS_RIGHT(1), .PTS_WRONG(0), .SATURATE(1))
    dut_a (.clk_count(clk_count), .rst_n(rst_n), .bus(if_a));
  score_keeper #(.N_TEAMS(4), .SCORE_W(4), .PTS_RIGHT(1), .PTS_WRONG(2), .SATURATE(1))
    dut_b (.clk_count(clk_count), .rst_n(rst_n), .bus(if_b));
  score_keeper #(.N_TEAMS(4), .SCORE_W(4), .PTS_RIGHT(1), .PTS_WRONG(2), .SATURATE(0))
    dut_c (.clk_count(clk_count), .rst_n(rst_n), .bus(if_c));
  score_keeper #(.N_TEAMS(8), .SCORE_W(6), .PTS_RIGHT(1), .PTS_WRONG(0), .SATURATE(1))
    dut_d (.clk_count(clk_count), .rst_n(rst_d), .bus(if_d));

  typedef struct packed {
    logic        t;
    logic        f;
    logic        clr;
    logic [3:0]  en;
    logic        zd;
    logic        err;
    logic [15:0] fs;
    logic [1:0]  lid;
    logic        lv;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic vt, input logic vf, input logic vc,
                              input logic [3:0] ven, input logic zd, input logic er,
                              input logic [15:0] fs, input logic [1:0] lid,
                              input logic lv);
    vec_t v;
    v.t = vt; v.f = vf; v.clr = vc; v.en = ven;
    v.zd = zd; v.err = er; v.fs = fs; v.lid = lid; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk_count);
    #1;
  endtask

  task automatic drive(input logic vt, input logic vf, input logic [3:0] ven);
    t = vt; f = vf; en = ven;
  endtask

  initial begin
    // Outputs listed are those seen after the edge that samples the inputs.
    // Lead fields lag by one edge, so they reflect the scores of the previous row.
    //            t  f  clr en       zd err fs        lid lv
    vecs[0]  = mk(1, 0, 0, 4'b0010, 1, 0, 16'h0010, 0, 0);
    vecs[1]  = mk(1, 0, 0, 4'b0010, 0, 0, 16'h0010, 1, 1);
    vecs[2]  = mk(1, 0, 0, 4'b0010, 0, 0, 16'h0010, 1, 1);
    vecs[3]  = mk(1, 0, 0, 4'b0010, 0, 0, 16'h0010, 1, 1);
    vecs[4]  = mk(1, 0, 0, 4'b0010, 0, 0, 16'h0010, 1, 1);
    vecs[5]  = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0010, 1, 1);
    vecs[6]  = mk(1, 0, 0, 4'b0110, 0, 1, 16'h0010, 1, 1);
    vecs[7]  = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0010, 1, 1);
    vecs[8]  = mk(1, 1, 0, 4'b0001, 0, 1, 16'h0010, 1, 1);
    vecs[9]  = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0010, 1, 1);
    vecs[10] = mk(0, 1, 0, 4'b1000, 1, 0, 16'h0010, 1, 1);
    vecs[11] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0010, 1, 1);
    vecs[12] = mk(1, 0, 0, 4'b0100, 1, 0, 16'h0110, 1, 1);
    vecs[13] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0110, 1, 1);
    vecs[14] = mk(1, 0, 0, 4'b0100, 1, 0, 16'h0210, 1, 1);
    vecs[15] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0210, 2, 1);
    vecs[16] = mk(1, 0, 0, 4'b1000, 1, 0, 16'h1210, 2, 1);
    vecs[17] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h1210, 2, 1);
    vecs[18] = mk(1, 0, 0, 4'b0010, 1, 0, 16'h1220, 2, 1);
    vecs[19] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h1220, 1, 1);
    vecs[20] = mk(1, 0, 0, 4'b0010, 1, 0, 16'h1230, 1, 1);
    vecs[21] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h1230, 1, 1);
    vecs[22] = mk(1, 0, 0, 4'b0100, 1, 0, 16'h1330, 1, 1);
    vecs[23] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h1330, 1, 1);
    vecs[24] = mk(1, 0, 1, 4'b0001, 0, 0, 16'h0000, 1, 1);
    vecs[25] = mk(1, 0, 0, 4'b0001, 0, 0, 16'h0000, 0, 0);
    vecs[26] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0000, 0, 0);
    vecs[27] = mk(1, 0, 0, 4'b0001, 1, 0, 16'h0001, 0, 0);
    vecs[28] = mk(0, 0, 0, 4'b0000, 0, 0, 16'h0001, 0, 1);

    rst_n = 1'b0; rst_d = 1'b0;
    t = 0; f = 0; clr = 0; en = '0;
    d_t = 0; d_f = 0; d_clr = 0; d_en = '0;
    step(); step();
    chk("reset zd_r",    64'(if_a.zd_r),    64'h0);
    chk("reset err",     64'(if_a.err),     64'h0);
    chk("reset EDA_fs",  64'(if_a.EDA_fs),  64'h0);
    chk("reset lead_id", 64'(if_a.lead_id), 64'h0);
    chk("reset lead_v",  64'(if_a.lead_v),  64'h0);
    rst_n = 1'b1;

    // Table: hold/one-shot, illegal inputs, zero penalty, leader, clear.
    for (int i = 0; i < NV; i++) begin
      t = vecs[i].t; f = vecs[i].f; clr = vecs[i].clr; en = vecs[i].en;
      step();
      chk($sformatf("v%0d zd_r", i),    64'(if_a.zd_r),    64'(vecs[i].zd));
      chk($sformatf("v%0d err", i),     64'(if_a.err),     64'(vecs[i].err));
      chk($sformatf("v%0d EDA_fs", i),  64'(if_a.EDA_fs),  64'(vecs[i].fs));
      chk($sformatf("v%0d lead_id", i), 64'(if_a.lead_id), 64'(vecs[i].lid));
      chk($sformatf("v%0d lead_v", i),  64'(if_a.lead_v),  64'(vecs[i].lv));
    end
    clr = 1'b0;

    // Upper boundary: saturate versus wrap on team 0.
    rst_n = 1'b0; drive(0, 0, 4'b0000); step(); rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      drive(1, 0, 4'b0001); step();
      drive(0, 0, 4'b0000); step();
    end
    chk("fill a", 64'(if_a.EDA_fs), 64'h000F);
    chk("fill b", 64'(if_b.EDA_fs), 64'h000F);
    chk("fill c", 64'(if_c.EDA_fs), 64'h000F);
    drive(1, 0, 4'b0001); step();
    chk("sat a fs", 64'(if_a.EDA_fs), 64'h000F);
    chk("sat a zd", 64'(if_a.zd_r),   64'h1);
    chk("sat b fs", 64'(if_b.EDA_fs), 64'h000F);
    chk("wrap c fs", 64'(if_c.EDA_fs), 64'h0000);
    chk("wrap c zd", 64'(if_c.zd_r),   64'h1);
    drive(0, 0, 4'b0000); step();

    // Lower boundary: penalty of 2 on team 3 holding 1.
    drive(1, 0, 4'b1000); step();
    drive(0, 0, 4'b0000); step();
    drive(0, 1, 4'b1000); step();
    chk("pen a fs", 64'(if_a.EDA_fs), 64'h100F);
    chk("pen a zd", 64'(if_a.zd_r),   64'h1);
    chk("pen b fs", 64'(if_b.EDA_fs), 64'h000F);
    chk("pen b zd", 64'(if_b.zd_r),   64'h1);
    chk("pen c fs", 64'(if_c.EDA_fs), 64'hF000);
    chk("pen c zd", 64'(if_c.zd_r),   64'h1);
    chk("pen c err", 64'(if_c.err),   64'h0);
    drive(0, 0, 4'b0000); step();

    // 8 teams x 6 bits: reset while a verdict is held in WAIT_REL.
    step();
    chk("d reset fs", 64'(if_d.EDA_fs), 64'h0);
    chk("d reset zd", 64'(if_d.zd_r),   64'h0);
    rst_d = 1'b1;
    d_t = 1'b1; d_en = 8'h20; step();
    chk("d apply fs", 64'(if_d.EDA_fs), 64'h1 << 30);
    chk("d apply zd", 64'(if_d.zd_r),   64'h1);
    step();
    chk("d hold zd",  64'(if_d.zd_r),    64'h0);
    chk("d lead_id",  64'(if_d.lead_id), 64'h5);
    chk("d lead_v",   64'(if_d.lead_v),  64'h1);
    rst_d = 1'b0; step();
    chk("d rst fs",   64'(if_d.EDA_fs),  64'h0);
    chk("d rst zd",   64'(if_d.zd_r),    64'h0);
    chk("d rst lid",  64'(if_d.lead_id), 64'h0);
    chk("d rst lv",   64'(if_d.lead_v),  64'h0);
    rst_d = 1'b1; step();
    chk("d reapply fs", 64'(if_d.EDA_fs), 64'h1 << 30);
    chk("d reapply zd", 64'(if_d.zd_r),   64'h1);
    step(); step();
    chk("d once fs", 64'(if_d.EDA_fs), 64'h1 << 30);
    chk("d once zd", 64'(if_d.zd_r),   64'h0);
    d_t = 1'b0; d_en = '0; step();
    chk("d rel fs",  64'(if_d.EDA_fs), 64'h1 << 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
